// File: rtl/trigger_event_capture_if.sv
// Event-drain interface: first-word fall-through event stream plus FIFO status.
interface trigger_event_capture_if #(
  parameter int TS_WIDTH   = 48,
  parameter int FIFO_DEPTH = 8
);
  localparam int EW = TS_WIDTH + 17;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [EW-1:0] evt_data;
  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] evt_count;
  logic          evt_overflow;

  modport master (
    output evt_data, evt_valid, evt_count, evt_overflow,
    input  evt_ready
  );

  modport slave (
    input  evt_data, evt_valid, evt_count, evt_overflow,
    output evt_ready
  );
endinterface

// File: rtl/trigger_event_capture.sv
// Trigger event capture: rising-edge detect on two trigger levels, per-channel
// stretched output pulses, and a timestamped event FIFO drained over valid/ready.
module trigger_event_capture #(
  parameter int TS_WIDTH   = 48,
  parameter int PW_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trig_enable,
  input  logic                 trigger0,
  input  logic                 trigger1,
  input  logic [15:0]          pulse_delay,
  input  logic [PW_WIDTH-1:0]  pulse_width,
  output logic                 trig_out0,
  output logic                 trig_out1,
  trigger_event_capture_if.master evt
);
  localparam int EW = TS_WIDTH + 17;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TS_WIDTH-1:0] TS_ONE = {{(TS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW_WIDTH-1:0] PW_ONE = {{(PW_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW_WIDTH-1:0] PW_ZERO = {PW_WIDTH{1'b0}};
  localparam logic [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] A_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} pstate_t;

  logic [TS_WIDTH-1:0] ts_r;
  logic [1:0]          prev_r;
  logic [1:0]          trig_s;
  logic [1:0]          rise_s;

  pstate_t             state_r [2];
  pstate_t             state_s [2];
  logic [PW_WIDTH-1:0] cnt_r [2];
  logic [PW_WIDTH-1:0] cnt_s [2];
  logic [1:0]          out_s;

  logic [EW-1:0]       word0_s, word1_s, push_word_s, pend_r;
  logic                pend_valid_r, push_s;

  logic [EW-1:0]       mem_r [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_r, rd_ptr_r, rd_next_s;
  logic [CW-1:0]       count_r, count_s, remaining_s;
  logic [EW-1:0]       data_r, head_s;
  logic                valid_r, ovf_r;
  logic                full_s, pop_s, wr_en_s, drop_s;

  assign trig_s = {trigger1, trigger0};
  assign rise_s = trig_s & ~prev_r & {2{trig_enable}};

  // Free-running timestamp and edge history; history tracks levels even while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_r   <= {TS_WIDTH{1'b0}};
      prev_r <= 2'b00;
    end else if (!trig_enable) begin
      ts_r   <= {TS_WIDTH{1'b0}};
      prev_r <= trig_s;
    end else begin
      ts_r   <= ts_r + TS_ONE;
      prev_r <= trig_s;
    end
  end

  // Pulse FSM state register, one per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        state_r[c] <= IDLE;
        cnt_r[c]   <= PW_ZERO;
      end
    end else if (!trig_enable) begin
      for (int c = 0; c < 2; c++) begin
        state_r[c] <= IDLE;
        cnt_r[c]   <= PW_ZERO;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        state_r[c] <= state_s[c];
        cnt_r[c]   <= cnt_s[c];
      end
    end
  end

  // Pulse FSM next state: start or retrigger on an edge, count down the remaining width.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      state_s[c] = state_r[c];
      cnt_s[c]   = cnt_r[c];
      case (state_r[c])
        IDLE: begin
          if (rise_s[c] && (pulse_width != PW_ZERO)) begin
            state_s[c] = ACTIVE;
            cnt_s[c]   = pulse_width - PW_ONE;
          end else begin
            state_s[c] = IDLE;
          end
        end
        ACTIVE: begin
          if (rise_s[c] && (pulse_width != PW_ZERO)) begin
            cnt_s[c] = pulse_width - PW_ONE;
          end else if (cnt_r[c] == PW_ZERO) begin
            state_s[c] = IDLE;
          end else begin
            cnt_s[c] = cnt_r[c] - PW_ONE;
          end
        end
        default: begin
          state_s[c] = IDLE;
          cnt_s[c]   = PW_ZERO;
        end
      endcase
    end
  end

  // Pulse FSM outputs: the line is high exactly while the channel is ACTIVE.
  always_comb begin
    out_s = 2'b00;
    for (int c = 0; c < 2; c++) begin
      out_s[c] = (state_r[c] == ACTIVE);
    end
  end

  assign trig_out0 = out_s[0];
  assign trig_out1 = out_s[1];

  assign word0_s = {1'b0, pulse_delay, ts_r};
  assign word1_s = {1'b1, pulse_delay, ts_r};

  // Push selection: a held ch1 word goes first; on a double edge ch0 goes now, ch1 waits.
  always_comb begin
    push_s      = 1'b0;
    push_word_s = word0_s;
    if (pend_valid_r) begin
      push_s      = 1'b1;
      push_word_s = pend_r;
    end else if (rise_s[0]) begin
      push_s      = 1'b1;
      push_word_s = word0_s;
    end else if (rise_s[1]) begin
      push_s      = 1'b1;
      push_word_s = word1_s;
    end else begin
      push_s      = 1'b0;
    end
  end

  // One-entry holding register for the ch1 word of a simultaneous edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r       <= {EW{1'b0}};
      pend_valid_r <= 1'b0;
    end else if (!trig_enable) begin
      pend_r       <= {EW{1'b0}};
      pend_valid_r <= 1'b0;
    end else if (!pend_valid_r && rise_s[0] && rise_s[1]) begin
      pend_r       <= word1_s;
      pend_valid_r <= 1'b1;
    end else begin
      pend_valid_r <= 1'b0;
    end
  end

  assign full_s  = (count_r == C_FULL);
  assign pop_s   = valid_r & evt.evt_ready;
  assign wr_en_s = push_s & (~full_s | pop_s);
  assign drop_s  = push_s & full_s & ~pop_s;

  // FIFO bookkeeping: next occupancy, read pointer and the head word presented next cycle.
  always_comb begin
    case ({wr_en_s, pop_s})
      2'b10:   count_s = count_r + C_ONE;
      2'b01:   count_s = count_r - C_ONE;
      default: count_s = count_r;
    endcase
    if (pop_s) begin
      rd_next_s   = rd_ptr_r + A_ONE;
      remaining_s = count_r - C_ONE;
    end else begin
      rd_next_s   = rd_ptr_r;
      remaining_s = count_r;
    end
    // When the FIFO drains to nothing, the word being pushed becomes the new head.
    if (remaining_s == C_ZERO) begin
      head_s = push_word_s;
    end else begin
      head_s = mem_r[rd_next_s];
    end
  end

  // FIFO storage, pointers and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {EW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= C_ZERO;
      data_r   <= {EW{1'b0}};
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (!trig_enable) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {EW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= C_ZERO;
      data_r   <= {EW{1'b0}};
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_word_s;
        wr_ptr_r        <= wr_ptr_r + A_ONE;
      end
      rd_ptr_r <= rd_next_s;
      count_r  <= count_s;
      valid_r  <= (count_s != C_ZERO);
      data_r   <= (count_s != C_ZERO) ? head_s : {EW{1'b0}};
      if (drop_s) ovf_r <= 1'b1;
    end
  end

  assign evt.evt_data     = data_r;
  assign evt.evt_valid    = valid_r;
  assign evt.evt_count    = count_r;
  assign evt.evt_overflow = ovf_r;
endmodule

// File: tb/tb_trigger_event_capture.sv
// Bench for trigger_event_capture: directed scenarios plus randomized traffic,
// a queue-based reference model, and a negedge monitor acting as scoreboard.
module tb_trigger_event_capture;
  localparam int TS_WIDTH   = 48;
  localparam int PW_WIDTH   = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int EW = TS_WIDTH + 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trig_enable = 1'b0;
  logic trigger0 = 1'b0;
  logic trigger1 = 1'b0;
  logic [15:0] pulse_delay = 16'h0000;
  logic [PW_WIDTH-1:0] pulse_width = '0;
  logic evt_ready = 1'b0;
  logic trig_out0, trig_out1;

  trigger_event_capture_if #(.TS_WIDTH(TS_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) evt_bus ();
  assign evt_bus.evt_ready = evt_ready;

  trigger_event_capture #(.TS_WIDTH(TS_WIDTH), .PW_WIDTH(PW_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .trig_enable(trig_enable),
    .trigger0(trigger0), .trigger1(trigger1),
    .pulse_delay(pulse_delay), .pulse_width(pulse_width),
    .trig_out0(trig_out0), .trig_out1(trig_out1),
    .evt(evt_bus.master)
  );

  always #4 clk = ~clk;

  // reference model state
  logic [TS_WIDTH-1:0] m_ts;
  bit m_prev0, m_prev1, m_ovf;
  int m_cnt, m_rem0, m_rem1;
  logic [EW-1:0] stage_q[$];
  logic [EW-1:0] exp_q[$];

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic int next_rem(bit rise, int rem, int pw);
    if (rise && pw != 0) return pw;
    return (rem > 0) ? rem - 1 : 0;
  endfunction

  task automatic model_reset();
    m_ts = '0; m_prev0 = 0; m_prev1 = 0; m_ovf = 0;
    m_cnt = 0; m_rem0 = 0; m_rem1 = 0;
    stage_q.delete(); exp_q.delete();
  endtask

  // one clock of the behaviour, evaluated at the rising edge from the applied inputs
  task automatic model_step();
    bit pop, r0, r1;
    logic [EW-1:0] w;
    if (!trig_enable) begin
      m_ts = '0; m_ovf = 0; m_cnt = 0; m_rem0 = 0; m_rem1 = 0;
      stage_q.delete(); exp_q.delete();
    end else begin
      pop = evt_ready && (m_cnt > 0);
      r0 = trigger0 && !m_prev0;
      r1 = trigger1 && !m_prev1;
      m_rem0 = next_rem(r0, m_rem0, int'(pulse_width));
      m_rem1 = next_rem(r1, m_rem1, int'(pulse_width));
      if (r0) stage_q.push_back({1'b0, pulse_delay, m_ts});
      if (r1) stage_q.push_back({1'b1, pulse_delay, m_ts});
      if (stage_q.size() > 0) begin
        w = stage_q.pop_front();
        if (m_cnt < FIFO_DEPTH || pop) begin
          exp_q.push_back(w);
          m_cnt++;
        end else begin
          m_ovf = 1;
        end
      end
      if (pop) m_cnt--;
      m_ts = m_ts + 1'b1;
    end
    m_prev0 = trigger0;
    m_prev1 = trigger1;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drain();
    evt_ready = 1'b1;
    repeat (12) step();
    evt_ready = 1'b0;
  endtask

  // monitor: compares every visible output with the model, pops words on handshake
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("evt_valid", evt_bus.evt_valid, m_cnt != 0);
        chk("evt_count", evt_bus.evt_count, m_cnt);
        chk("evt_overflow", evt_bus.evt_overflow, m_ovf);
        chk("trig_out0", trig_out0, m_rem0 > 0);
        chk("trig_out1", trig_out1, m_rem1 > 0);
        if (evt_bus.evt_valid) begin
          if (exp_q.size() == 0) begin
            chk("evt_data_unexpected", 1'b1, 1'b0);
          end else begin
            chk("evt_data", evt_bus.evt_data, exp_q[0]);
            if (evt_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int hc;
    int ready_pct;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_valid", evt_bus.evt_valid, 1'b0);
    chk("reset_count", evt_bus.evt_count, 0);
    chk("reset_ovf", evt_bus.evt_overflow, 1'b0);
    chk("reset_data", evt_bus.evt_data, 0);
    chk("reset_out", {trig_out1, trig_out0}, 2'b00);

    // edge at ts=100 with a 4-cycle pulse
    pulse_width = 16'd4; pulse_delay = 16'h1234;
    step();
    trig_enable = 1'b1;
    repeat (100) step();
    trigger0 = 1'b1;
    step();
    chk("t1_ts", evt_bus.evt_data[TS_WIDTH-1:0], 100);
    chk("t1_delay", evt_bus.evt_data[TS_WIDTH+15:TS_WIDTH], 16'h1234);
    chk("t1_chan", evt_bus.evt_data[EW-1], 1'b0);
    chk("t1_out_first", trig_out0, 1'b1);
    trigger0 = 1'b0;
    repeat (3) step();
    chk("t1_out_last", trig_out0, 1'b1);
    step();
    chk("t1_out_end", trig_out0, 1'b0);
    drain();

    // simultaneous edges on both channels
    trigger0 = 1'b1; trigger1 = 1'b1; pulse_delay = 16'h0abc;
    step();
    step();
    chk("t2_count", evt_bus.evt_count, 2);
    trigger0 = 1'b0; trigger1 = 1'b0;
    drain();

    // overflow: nine edges into an undrained FIFO
    trig_enable = 1'b0; step(); trig_enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pulse_delay = 16'(i);
      trigger0 = 1'b1; step();
      trigger0 = 1'b0; step();
    end
    chk("t3_count", evt_bus.evt_count, 8);
    chk("t3_ovf", evt_bus.evt_overflow, 1'b1);
    drain();

    // full FIFO with simultaneous push and pop
    trig_enable = 1'b0; step(); trig_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      trigger0 = 1'b1; step();
      trigger0 = 1'b0; step();
    end
    pulse_delay = 16'hbeef;
    trigger0 = 1'b1; evt_ready = 1'b1;
    step();
    chk("t4_count", evt_bus.evt_count, 8);
    chk("t4_ovf", evt_bus.evt_overflow, 1'b0);
    trigger0 = 1'b0; evt_ready = 1'b0;
    drain();

    // retrigger extends the pulse; zero width logs without a pulse
    pulse_width = 16'd10; evt_ready = 1'b1; trigger0 = 1'b1; hc = 0;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (trig_out0) hc++;
      trigger0 = (k == 5);
    end
    chk("t5_high_cycles", hc, 15);
    pulse_width = 16'd0; evt_ready = 1'b0; trigger0 = 1'b1;
    step();
    chk("t5_pw0_out", trig_out0, 1'b0);
    chk("t5_pw0_count", evt_bus.evt_count, 1);
    trigger0 = 1'b0;
    drain();

    // level already high at enable, then async reset mid-pulse
    trigger1 = 1'b1; trig_enable = 1'b0;
    step();
    trig_enable = 1'b1;
    repeat (5) step();
    chk("t6_no_event", evt_bus.evt_count, 0);
    trigger1 = 1'b0; step();
    pulse_width = 16'd8; trigger1 = 1'b1; step();
    trigger1 = 1'b0; step();
    chk("t6_pulse_on", trig_out1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out1", trig_out1, 1'b0);
    chk("t6_rst_valid", evt_bus.evt_valid, 1'b0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // randomized traffic
    ready_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) ready_pct = $urandom_range(5, 95);
      trig_enable = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 19) == 0) begin
        trigger0 = 1'b1; trigger1 = 1'b1;
      end else begin
        if ($urandom_range(0, 3) == 0) trigger0 = ~trigger0;
        if ($urandom_range(0, 3) == 0) trigger1 = ~trigger1;
      end
      pulse_width = 16'($urandom_range(0, 12));
      pulse_delay = 16'($urandom);
      evt_ready = ($urandom_range(0, 99) < ready_pct);
      step();
    end
    trigger0 = 1'b0; trigger1 = 1'b0; trig_enable = 1'b1;
    drain();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
